lcd_frame_scheduler: RTL and testbench



---
 rtl/lcd_frame_scheduler.sv | 148 ++++++++++++++
 tb/tb_lcd_frame_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - selects background or a timed overlay frame for the 2x16 LCD
// Overlay 2 outranks overlay 1; every switch is gated by a minimum dwell except overlay expiry.
module lcd_frame_scheduler #(
  parameter int MFREQ_KHZ    = 1,
  parameter int MIN_DWELL_MS = 320,
  parameter int HOLD1_MS     = 2000,
  parameter int HOLD2_MS     = 5000
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic [127:0] base_lineA,
  input  logic [127:0] base_lineB,
  input  logic [127:0] ovl1_lineA,
  input  logic [127:0] ovl1_lineB,
  input  logic [127:0] ovl2_lineA,
  input  logic [127:0] ovl2_lineB,
  input  logic [1:0]   req,
  output logic [1:0]   grant,
  output logic [1:0]   done,
  output logic [127:0] LineA,
  output logic [127:0] LineB,
  output logic         frame_chg
);

  localparam int PW   = (MFREQ_KHZ > 1) ? $clog2(MFREQ_KHZ) : 1;
  localparam int DW   = (MIN_DWELL_MS > 0) ? $clog2(MIN_DWELL_MS + 1) : 1;
  localparam int H1E  = (HOLD1_MS == 0) ? 1 : HOLD1_MS;
  localparam int H2E  = (HOLD2_MS == 0) ? 1 : HOLD2_MS;
  localparam int HMAX = (H1E > H2E) ? H1E : H2E;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(MFREQ_KHZ - 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL_MS);
  localparam logic [HW-1:0] H1_LAST    = HW'(H1E - 1);
  localparam logic [HW-1:0] H2_LAST    = HW'(H2E - 1);

  typedef enum logic [1:0] {
    ST_BASE = 2'd0,
    ST_OVL1 = 2'd1,
    ST_OVL2 = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [PW-1:0]  r_presc;
  logic [DW-1:0]  r_dwell;
  logic [HW-1:0]  r_hold;
  logic [1:0]     r_grant;
  logic [1:0]     r_done;
  logic           r_chg;
  logic [127:0]   r_line_a;
  logic [127:0]   r_line_b;

  logic           w_tick;
  logic           w_dwell_ok;
  logic           w_expire;
  logic           w_switch;
  logic [1:0]     w_done;
  logic [127:0]   w_line_a;
  logic [127:0]   w_line_b;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_dwell_ok = (r_dwell == DWELL_MAX);

  always_comb begin
    w_next_state = r_state;
    w_expire     = 1'b0;
    case (r_state)
      ST_BASE: begin
        if (w_dwell_ok && req[1])      w_next_state = ST_OVL2;
        else if (w_dwell_ok && req[0]) w_next_state = ST_OVL1;
      end
      ST_OVL1: begin
        // Hold counts completed ticks, so the expiring tick is the one seen at HOLD-1.
        w_expire = w_tick && (r_hold == H1_LAST);
        if (w_dwell_ok && req[1]) w_next_state = ST_OVL2;
        else if (w_expire)        w_next_state = ST_BASE;
      end
      ST_OVL2: begin
        w_expire = w_tick && (r_hold == H2_LAST);
        if (w_expire) w_next_state = ST_BASE;
      end
      default: w_next_state = ST_BASE;
    endcase
  end

  assign w_switch = (w_next_state != r_state);

  always_comb begin
    w_done = 2'b00;
    if (w_switch && r_state == ST_OVL1) w_done[0] = 1'b1;
    if (w_switch && r_state == ST_OVL2) w_done[1] = 1'b1;
  end

  // Overlay frames are captured once on entry; the background frame tracks live.
  always_comb begin
    w_line_a = r_line_a;
    w_line_b = r_line_b;
    case (w_next_state)
      ST_BASE: begin
        w_line_a = base_lineA;
        w_line_b = base_lineB;
      end
      ST_OVL1: if (w_switch) begin
        w_line_a = ovl1_lineA;
        w_line_b = ovl1_lineB;
      end
      ST_OVL2: if (w_switch) begin
        w_line_a = ovl2_lineA;
        w_line_b = ovl2_lineB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state  <= ST_BASE;
      r_presc  <= '0;
      r_dwell  <= DWELL_MAX;
      r_hold   <= '0;
      r_grant  <= 2'b00;
      r_done   <= 2'b00;
      r_chg    <= 1'b0;
      r_line_a <= '0;
      r_line_b <= '0;
    end else begin
      r_state  <= w_next_state;
      r_presc  <= w_tick ? '0 : r_presc + 1'b1;
      if (w_switch)                  r_dwell <= '0;
      else if (w_tick && !w_dwell_ok) r_dwell <= r_dwell + 1'b1;
      if (w_switch || w_next_state == ST_BASE) r_hold <= '0;
      else if (w_tick)                         r_hold <= r_hold + 1'b1;
      r_grant  <= {w_next_state == ST_OVL2, w_next_state == ST_OVL1};
      r_done   <= w_done;
      r_chg    <= w_switch;
      r_line_a <= w_line_a;
      r_line_b <= w_line_b;
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign frame_chg = r_chg;
  assign LineA     = r_line_a;
  assign LineB     = r_line_b;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb/tb_lcd_frame_scheduler.sv - bench for lcd_frame_scheduler against a ms-level behavioural model
module tb_lcd_frame_scheduler;

  localparam int MF  = 4;
  localparam int MIN = 2;
  localparam int H1  = 3;
  localparam int H2  = 5;

  logic         mclk = 1'b0;
  logic         rst  = 1'b1;
  logic         rst2 = 1'b1;
  logic [1:0]   req  = 2'b00;
  logic [1:0]   req2 = 2'b00;
  logic [127:0] base_la, base_lb, o1_la, o1_lb, o2_la, o2_lb;
  logic [1:0]   grant, done, g2, d2;
  logic [127:0] line_a, line_b, la2, lb2;
  logic         chg, c2;

  always #5 mclk = ~mclk;

  lcd_frame_scheduler #(.MFREQ_KHZ(MF), .MIN_DWELL_MS(MIN), .HOLD1_MS(H1), .HOLD2_MS(H2)) dut (
    .mclk(mclk), .rst(rst),
    .base_lineA(base_la), .base_lineB(base_lb),
    .ovl1_lineA(o1_la), .ovl1_lineB(o1_lb),
    .ovl2_lineA(o2_la), .ovl2_lineB(o2_lb),
    .req(req), .grant(grant), .done(done),
    .LineA(line_a), .LineB(line_b), .frame_chg(chg)
  );

  lcd_frame_scheduler #(.MFREQ_KHZ(MF), .MIN_DWELL_MS(MIN), .HOLD1_MS(0), .HOLD2_MS(H2)) dut2 (
    .mclk(mclk), .rst(rst2),
    .base_lineA(base_la), .base_lineB(base_lb),
    .ovl1_lineA(o1_la), .ovl1_lineB(o1_lb),
    .ovl2_lineA(o2_la), .ovl2_lineB(o2_lb),
    .req(req2), .grant(g2), .done(d2),
    .LineA(la2), .LineB(lb2), .frame_chg(c2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: elapsed time measured in whole ms since reset, dwell/hold as ms since last switch.
  int           m_cyc, m_mode, m_next, m_dwell, m_hold;
  logic         m_tick, m_ok, m_exp;
  logic [1:0]   e_grant, e_done;
  logic         e_chg;
  logic [127:0] e_la, e_lb;

  function automatic int hold_len(input int mode);
    return (mode == 1) ? H1 : H2;
  endfunction

  always @(posedge mclk) begin
    if (rst) begin
      m_cyc = 0; m_mode = 0; m_dwell = MIN; m_hold = 0;
      e_grant = 2'b00; e_done = 2'b00; e_chg = 1'b0; e_la = '0; e_lb = '0;
    end else begin
      m_tick = ((m_cyc % MF) == MF - 1);
      m_cyc++;
      m_ok   = (m_dwell >= MIN);
      m_exp  = (m_mode != 0) && m_tick && (m_hold + 1 >= hold_len(m_mode));
      m_next = m_mode;
      if (m_mode == 0) begin
        if (m_ok && req[1]) m_next = 2;
        else if (m_ok && req[0]) m_next = 1;
      end else if (m_mode == 1) begin
        if (m_ok && req[1]) m_next = 2;
        else if (m_exp) m_next = 0;
      end else if (m_exp) begin
        m_next = 0;
      end
      e_chg  = (m_next != m_mode);
      e_done = (e_chg && m_mode != 0) ? 2'(1 << (m_mode - 1)) : 2'b00;
      if (e_chg) begin
        m_dwell = 0; m_hold = 0;
      end else if (m_tick) begin
        m_dwell++;
        if (m_next != 0) m_hold++;
      end
      e_grant = (m_next == 0) ? 2'b00 : 2'(1 << (m_next - 1));
      if (m_next == 0) begin
        e_la = base_la; e_lb = base_lb;
      end else if (e_chg) begin
        e_la = (m_next == 1) ? o1_la : o2_la;
        e_lb = (m_next == 1) ? o1_lb : o2_lb;
      end
      m_mode = m_next;
    end
  end

  logic chk_en    = 1'b0;
  logic prev_chg  = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge mclk) begin
    if (chk_en) begin
      chk("grant", grant, e_grant);
      chk("done", done, e_done);
      chk("frame_chg", chg, e_chg);
      chk("LineA", line_a, e_la);
      chk("LineB", line_b, e_lb);
      chk("grant_onehot0", $onehot0(grant), 1'b1);
      if (prev_chg)  chk("chg_not_consecutive", chg, 1'b0);
      if (prev_done) chk("done_not_consecutive", |done, 1'b0);
      prev_chg  = chg;
      prev_done = |done;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge mclk);
  endtask

  logic [127:0] saved;

  initial begin
    base_la = rnd128(); base_lb = rnd128();
    o1_la = rnd128(); o1_lb = rnd128(); o2_la = rnd128(); o2_lb = rnd128();

    // Reset state and simple overlay 1 run
    step(2);
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_chg", chg, 1'b0);
    chk("rst_LineA", line_a, 128'd0);
    chk_en = 1'b1;
    rst = 1'b0; req = 2'b01;
    step(1);
    chk("o1_grant", grant, 2'b01);
    chk("o1_chg", chg, 1'b1);
    chk("o1_LineA", line_a, o1_la);
    saved = o1_la;
    o1_la = rnd128();
    step(10);
    chk("o1_frozen", line_a, saved);
    chk("o1_still", grant, 2'b01);
    step(1);
    chk("o1_exp_grant", grant, 2'b00);
    chk("o1_exp_done", done, 2'b01);
    chk("o1_exp_chg", chg, 1'b1);
    chk("o1_exp_LineA", line_a, base_la);
    req = 2'b00;
    base_la = rnd128();
    step(1);
    chk("base_live", line_a, base_la);
    chk("base_live_chg", chg, 1'b0);

    // Simultaneous requests, then overlay 1 after dwell, then preemption
    rst = 1'b1; step(1);
    rst = 1'b0; req = 2'b11;
    step(1);
    chk("both_grant", grant, 2'b10);
    req = 2'b01;
    step(19);
    chk("o2_exp_grant", grant, 2'b00);
    chk("o2_exp_done", done, 2'b10);
    step(8);
    chk("dwell_wait", grant, 2'b00);
    step(1);
    chk("o1_after_dwell", grant, 2'b01);
    req = 2'b11;
    step(7);
    chk("preempt_wait", grant, 2'b01);
    step(1);
    chk("preempt_grant", grant, 2'b10);
    chk("preempt_done", done, 2'b01);
    chk("preempt_chg", chg, 1'b1);

    // Reset in the middle of overlay 2
    req = 2'b10;
    step(3);
    rst = 1'b1;
    step(1);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_done", done, 2'b00);
    chk("midrst_LineA", line_a, 128'd0);
    rst = 1'b0;
    step(1);
    chk("midrst_regrant", grant, 2'b10);
    req = 2'b00;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 23) == 0) req[1] = ~req[1];
      if ($urandom_range(0, 3) == 0) begin base_la = rnd128(); base_lb = rnd128(); end
      if ($urandom_range(0, 15) == 0) begin o1_la = rnd128(); o1_lb = rnd128(); end
      if ($urandom_range(0, 15) == 0) begin o2_la = rnd128(); o2_lb = rnd128(); end
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0; req = 2'b00;

    // HOLD1_MS = 0 behaves as a one-tick hold
    step(1);
    chk("h0_rst_grant", g2, 2'b00);
    rst2 = 1'b0; req2 = 2'b01;
    step(1);
    chk("h0_grant", g2, 2'b01);
    chk("h0_LineA", la2, o1_la);
    step(2);
    chk("h0_still", g2, 2'b01);
    req2 = 2'b00;
    step(1);
    chk("h0_exp_grant", g2, 2'b00);
    chk("h0_exp_done", d2, 2'b01);
    chk("h0_exp_chg", c2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
